counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Hardware scoreboard that sits beside `counter_up_dwn` and watches the same pins: `data`, `load`, `up_dwn`, `out`.
- Keeps a cycle-accurate reference model of the load/up/down counter and compares the DUT output against it every clock.
- Reports per-cycle mismatches, saturating check and error counts, and the first failing value pair.
- Synthesizable, so the same block works in the simulation bench and as an on-chip self-check.

Parameters:
- WIDTH, 4, width of `data`, `out` and the model register.
- CNT_W, 16, width of the check and error counters (saturating).
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch and stop checking; 0 = keep checking.

Ports:
- clk  input  1  single clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-high reset; the same net that drives the DUT.
- check_en  input  1  1 = compare each cycle; 0 = model tracks but no compare.
- data  input  WIDTH  DUT load value (snooped).
- load  input  1  DUT load strobe (snooped).
- up_dwn  input  1  DUT direction, 1 = up (snooped).
- out  input  WIDTH  DUT counter output (snooped).
- expected  output  WIDTH  current model value.
- mismatch  output  1  registered one-cycle pulse on a failed compare.
- chk_cnt  output  CNT_W  number of compares performed.
- err_cnt  output  CNT_W  number of failed compares.
- first_exp  output  WIDTH  model value at the first error.
- first_got  output  WIDTH  DUT value at the first error.
- halted  output  1  1 while in HALT.

Behaviour:
- Reset (asynchronous, active-high) clears every output and internal register:
  - `expected`, `chk_cnt`, `err_cnt`, `first_exp`, `first_got` = 0.
  - `mismatch`, `halted` = 0.
  - state = IDLE; `seen_err` flag = 0.
- Model update, at each posedge with reset low:
  - `load` = 1 → model = `data` (load has priority over direction).
  - else `up_dwn` = 1 → model = model + 1, modulo 2^WIDTH.
  - else model = model − 1, modulo 2^WIDTH.
  - Wrap: 15 + 1 → 0 and 0 − 1 → 15 (WIDTH = 4).
  - The model updates in every state, including IDLE and HALT, so it never loses sync.
- Compare timing, at posedge N:
  - Compare the pre-edge `out` with the pre-edge model value; both reflect edge N−1.
  - Result is registered: `mismatch` is high during cycle N+1 only.
- State machine:
  - IDLE: no compares. Go to CHECK when `check_en` = 1.
  - CHECK: compare every cycle.
    - Go to IDLE when `check_en` = 0; that edge performs no compare.
    - On a mismatch with STOP_ON_ERR = 1, go to HALT.
  - HALT: no compares, `halted` = 1. Exit only by reset.
- Counters:
  - `chk_cnt` increments on every compare; `err_cnt` increments on every failed compare.
  - Both saturate at all-ones and never wrap.
- First-error capture: on the first mismatch since reset, latch `first_exp`/`first_got` and set `seen_err`. Later errors leave the capture unchanged.
- Reset mid-run: all state is cleared immediately, including the counts. Because the model also resets to 0, a DUT whose reset clears to 0 compares clean from the first edge after release.
- `load` asserted together with a direction change: load wins; direction is ignored that cycle.
- `check_en` asserted in the same cycle as reset release: the first compare happens at the second posedge after release.

Decomposition:
- Package `counter_chk_pkg`:
  - typedef `chk_state_t` {IDLE, CHECK, HALT}.
  - localparam defaults for WIDTH and CNT_W.
- One natural sub-module, `counter_ref_model`: model register plus next-value logic, with ports clk, reset, data, load, up_dwn, expected. The top level holds the FSM, compare, counters and capture.

Test Plan:
- Load 0, count up 4 cycles with `check_en` = 1 → `expected` reads 0,1,2,3,4; `chk_cnt` = 5; `err_cnt` = 0; `mismatch` never high.
- Load 4'hF, count down 3 cycles; separately load 4'hE, count up 3 cycles → sequences F,E,D,C and E,F,0,1 (wrap both ways); no errors.
- Force `out` = 4'h7 while the model = 4'h5, STOP_ON_ERR = 0 → `mismatch` pulses for exactly 1 cycle, one edge later; `err_cnt` = 1; `first_exp` = 5; `first_got` = 7; checking continues.
- Same fault with STOP_ON_ERR = 1, then inject a second fault → `halted` = 1; `err_cnt` stays 1; `chk_cnt` frozen; first capture unchanged.
- Load 4, count up 2, pulse reset for 1 cycle mid-count → all outputs return to 0 asynchronously, before the next edge; after release the model counts 0,1,2 in step with the DUT; `err_cnt` = 0.
- Load 2, count up 2 cycles, flip `up_dwn` to 0, drop `check_en` for 2 cycles, re-enable → `expected` = 2,3,4,3,2,1; no compares while disabled; the model stays in sync; `err_cnt` = 0.

Source files
------------

// File: rtl/counter_chk_pkg.sv
// Shared types and defaults for the counter scoreboard.
//   chk_state_t : checker FSM states
//   WIDTH_DEF   : default counter / data width
//   CNT_W_DEF   : default width of the check and error counters
package counter_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } chk_state_t;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/counter_ref_model.sv
// Reference model of the load/up/down counter being watched.
// Ports:
//   clk, reset : clock and async active-high reset (model clears to 0)
//   data, load : load value and strobe (load wins over direction)
//   up_dwn     : 1 = count up, 0 = count down, modulo 2^WIDTH
//   expected   : current model value
module counter_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             up_dwn,
  output logic [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] model_next;

  always_comb begin
    model_next = expected;
    if (load)        model_next = data;
    else if (up_dwn) model_next = expected + WIDTH'(1);
    else             model_next = expected - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) expected <= '0;
    else       expected <= model_next;
  end

endmodule

// File: rtl/counter_checker.sv
// Scoreboard that snoops a load/up/down counter and compares its output
// against a cycle-accurate reference model every clock.
// Ports:
//   clk, reset          : clock and async active-high reset (shared with the watched counter)
//   check_en            : enables per-cycle compares
//   data, load, up_dwn  : snooped counter controls
//   out                 : snooped counter output
//   expected            : current model value
//   mismatch            : registered one-cycle pulse on a failed compare
//   chk_cnt, err_cnt    : saturating compare / error counts
//   first_exp/first_got : model and counter values at the first error since reset
//   halted              : high while stopped after an error (STOP_ON_ERR = 1)
//
// state | meaning
// IDLE  | model tracks, no compares; leaves when check_en rises
// CHECK | compare every edge while check_en is high
// HALT  | stopped after an error; model still tracks; left only by reset
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             up_dwn,
  input  logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic             halted
);

  chk_state_t state, state_next;
  logic       do_cmp;
  logic       fail;
  logic       seen_err;

  counter_ref_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .up_dwn   (up_dwn),
    .expected (expected)
  );

  // The compare uses the pre-edge model value and pre-edge out; both
  // reflect the previous edge, so the two stay aligned.
  always_comb begin
    state_next = state;
    do_cmp     = 1'b0;
    case (state)
      IDLE: begin
        if (check_en) state_next = CHECK;
      end
      CHECK: begin
        if (!check_en) begin
          state_next = IDLE;
        end else begin
          do_cmp = 1'b1;
          if (STOP_ON_ERR && (out != expected)) state_next = HALT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fail   = do_cmp && (out != expected);
  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mismatch  <= 1'b0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      first_exp <= '0;
      first_got <= '0;
      seen_err  <= 1'b0;
    end else begin
      state    <= state_next;
      mismatch <= fail;
      if (do_cmp && (chk_cnt != {CNT_W{1'b1}})) chk_cnt <= chk_cnt + CNT_W'(1);
      if (fail && (err_cnt != {CNT_W{1'b1}}))   err_cnt <= err_cnt + CNT_W'(1);
      if (fail && !seen_err) begin
        first_exp <= expected;
        first_got <= out;
        seen_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       check_en;
  logic [3:0] data;
  logic       load;
  logic       up_dwn;
  logic [3:0] out;
  logic       force_en;
  logic [3:0] force_val;
  logic [3:0] dut_cnt;

  logic [3:0]  exp0, exp1, fe0, fg0, fe1, fg1;
  logic        mm0, mm1, h0, h1;
  logic [15:0] chk0, chk1, err0, err1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in for the watched counter, with an override for fault injection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dut_cnt <= 4'h0;
    else if (load)   dut_cnt <= data;
    else if (up_dwn) dut_cnt <= dut_cnt + 4'h1;
    else             dut_cnt <= dut_cnt - 4'h1;
  end
  assign out = force_en ? force_val : dut_cnt;

  counter_checker #(.WIDTH(4), .CNT_W(16), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .reset(reset), .check_en(check_en), .data(data), .load(load),
    .up_dwn(up_dwn), .out(out), .expected(exp0), .mismatch(mm0), .chk_cnt(chk0),
    .err_cnt(err0), .first_exp(fe0), .first_got(fg0), .halted(h0)
  );

  counter_checker #(.WIDTH(4), .CNT_W(16), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .reset(reset), .check_en(check_en), .data(data), .load(load),
    .up_dwn(up_dwn), .out(out), .expected(exp1), .mismatch(mm1), .chk_cnt(chk1),
    .err_cnt(err1), .first_exp(fe1), .first_got(fg1), .halted(h1)
  );

  typedef struct packed {
    logic       ce;
    logic       ld;
    logic [3:0] d;
    logic       ud;
    logic [3:0] e_exp;
    logic [15:0] e_chk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ce, input logic ld, input logic [3:0] d,
                     input logic ud, input logic [3:0] e_exp, input logic [15:0] e_chk);
    vec_t v;
    v.ce = ce; v.ld = ld; v.d = d; v.ud = ud; v.e_exp = e_exp; v.e_chk = e_chk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; check_en = 1'b0; data = 4'h0; load = 1'b0; up_dwn = 1'b1;
    force_en = 1'b0; force_val = 4'h0;

    //   ce  ld  d     ud  expected chk
    add(1, 1, 4'h0, 1, 4'h0, 0);   // IDLE -> CHECK, no compare
    add(1, 1, 4'h0, 1, 4'h0, 1);
    add(1, 0, 4'h0, 1, 4'h1, 2);
    add(1, 0, 4'h0, 1, 4'h2, 3);
    add(1, 0, 4'h0, 1, 4'h3, 4);
    add(1, 0, 4'h0, 1, 4'h4, 5);
    add(1, 1, 4'hF, 1, 4'hF, 6);
    add(1, 0, 4'h0, 0, 4'hE, 7);
    add(1, 0, 4'h0, 0, 4'hD, 8);
    add(1, 0, 4'h0, 0, 4'hC, 9);
    add(1, 1, 4'hE, 0, 4'hE, 10);
    add(1, 0, 4'h0, 1, 4'hF, 11);
    add(1, 0, 4'h0, 1, 4'h0, 12);  // wrap up
    add(1, 0, 4'h0, 1, 4'h1, 13);
    add(1, 1, 4'h9, 0, 4'h9, 14);  // load beats direction change
    add(1, 1, 4'h2, 1, 4'h2, 15);
    add(1, 0, 4'h0, 1, 4'h3, 16);
    add(1, 0, 4'h0, 1, 4'h4, 17);
    add(1, 0, 4'h0, 0, 4'h3, 18);
    add(0, 0, 4'h0, 0, 4'h2, 18);  // CHECK -> IDLE, no compare
    add(0, 0, 4'h0, 0, 4'h1, 18);
    add(1, 0, 4'h0, 0, 4'h0, 18);  // IDLE -> CHECK, no compare
    add(1, 0, 4'h0, 0, 4'hF, 19);  // wrap down, compare

    step(); step();
    check("rst_expected", 32'(exp0), 32'h0);
    check("rst_chk_cnt",  32'(chk0), 32'h0);
    check("rst_err_cnt",  32'(err0), 32'h0);
    check("rst_mismatch", 32'(mm0),  32'h0);
    check("rst_first",    32'({fe0, fg0}), 32'h0);
    check("rst_halted",   32'(h1),   32'h0);

    reset = 1'b0;
    foreach (vecs[i]) begin
      check_en = vecs[i].ce; load = vecs[i].ld; data = vecs[i].d; up_dwn = vecs[i].ud;
      step();
      check($sformatf("vec%0d_expected", i), 32'(exp0), 32'(vecs[i].e_exp));
      check($sformatf("vec%0d_chk_cnt", i),  32'(chk0), 32'(vecs[i].e_chk));
      check($sformatf("vec%0d_err_cnt", i),  32'(err0), 32'h0);
      check($sformatf("vec%0d_mismatch", i), 32'(mm0),  32'h0);
      check($sformatf("vec%0d_u1_chk", i),   32'(chk1), 32'(vecs[i].e_chk));
    end

    // Single fault: out forced to 7 while the model holds 5.
    check_en = 1'b1; load = 1'b1; data = 4'h5; up_dwn = 1'b1;
    step();
    check("pre_fault_chk", 32'(chk0), 32'd20);
    force_en = 1'b1; force_val = 4'h7;
    check("pre_fault_mismatch", 32'(mm0), 32'h0);
    step();
    check("fault_mismatch",  32'(mm0), 32'h1);
    check("fault_err_cnt",   32'(err0), 32'h1);
    check("fault_chk_cnt",   32'(chk0), 32'd21);
    check("fault_first_exp", 32'(fe0), 32'h5);
    check("fault_first_got", 32'(fg0), 32'h7);
    check("halt_halted",     32'(h1), 32'h1);
    check("halt_mismatch",   32'(mm1), 32'h1);
    check("halt_err_cnt",    32'(err1), 32'h1);
    check("halt_first",      32'({fe1, fg1}), 32'h57);
    check("run_halted",      32'(h0), 32'h0);
    force_en = 1'b0;
    step();
    check("pulse_end",       32'(mm0), 32'h0);
    check("continue_chk",    32'(chk0), 32'd22);
    check("halt_chk_frozen", 32'(chk1), 32'd21);
    force_en = 1'b1; force_val = 4'h3;
    step();
    check("fault2_mismatch",  32'(mm0), 32'h1);
    check("fault2_err_cnt",   32'(err0), 32'h2);
    check("fault2_first",     32'({fe0, fg0}), 32'h57);
    check("halt2_mismatch",   32'(mm1), 32'h0);
    check("halt2_err_cnt",    32'(err1), 32'h1);
    check("halt2_chk_cnt",    32'(chk1), 32'd21);
    check("halt2_first",      32'({fe1, fg1}), 32'h57);
    force_en = 1'b0; load = 1'b0; up_dwn = 1'b1;
    step();
    check("halt_model_tracks", 32'(exp1), 32'h6);
    check("halt_still",        32'(h1), 32'h1);

    // Reset mid-count.
    load = 1'b1; data = 4'h4;
    step();
    load = 1'b0;
    step(); step();
    check("pre_reset_expected", 32'(exp0), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    check("async_expected", 32'(exp0), 32'h0);
    check("async_chk_cnt",  32'(chk0), 32'h0);
    check("async_err_cnt",  32'(err0), 32'h0);
    check("async_first",    32'({fe0, fg0}), 32'h0);
    check("async_halted",   32'(h1), 32'h0);
    check("async_u1_err",   32'(err1), 32'h0);
    step();
    reset = 1'b0; check_en = 1'b1; load = 1'b0; up_dwn = 1'b1;
    step();
    check("rel1_expected", 32'(exp0), 32'h1);
    check("rel1_chk_cnt",  32'(chk0), 32'h0);
    step();
    check("rel2_expected", 32'(exp0), 32'h2);
    check("rel2_chk_cnt",  32'(chk0), 32'h1);
    step();
    check("rel3_expected", 32'(exp0), 32'h3);
    check("rel3_chk_cnt",  32'(chk0), 32'h2);
    check("rel3_err_cnt",  32'(err0), 32'h0);
    check("rel3_u1_err",   32'(err1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
